milano_mdu: RTL
===============

Name: milano_mdu

Overview:
- Parametrised iterative multiply/divide unit for the milano core; executes the RV32M/RV64M OPCODE_OP funct7=0000001 group.
- Sits beside the single-cycle ALU in the execute stage and extends the core's ALU operation set with multi-cycle operations.
- Uses a valid/ready request and result handshake, so the pipeline stalls on it cleanly.
- Radix-2: one multiply or divide step per cycle.

Parameters:
- XLEN, 32: operand and result width; legal values are 32 and 64.
- TAG_W, 5: width of the opaque tag, typically the destination register index, carried from request to result.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- op_valid_i  input  1  request valid.
- op_ready_o  output  1  unit can accept a request; high only in IDLE.
- op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a_i  input  XLEN  rs1 value.
- operand_b_i  input  XLEN  rs2 value.
- tag_i  input  TAG_W  request tag.
- kill_i  input  1  flush; abandons any in-flight operation.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  consumer accepts the result.
- result_o  output  XLEN  result.
- res_tag_o  output  TAG_W  tag of the result.
- busy_o  output  1  high when state is not IDLE.

Behaviour:
- Reset:
  - state=IDLE, res_valid_o=0, result_o=0, res_tag_o=0, busy_o=0, op_ready_o=1, step counter=0.
  - Reset has priority over everything, including mid-operation; the in-flight result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - op_ready_o=1.
  - Accept when op_valid_i && op_ready_o && !kill_i.
  - Latch op_i, tag_i, and the magnitudes of the operands. A signed operand is negated when its MSB is set: a and b for MULH, DIV and REM; a only for MULHSU; neither for MUL, MULHU, DIVU and REMU.
  - Latch the result-negate flag: sign_a^sign_b for MUL-type ops and DIV; sign_a for REM.
  - Go to CALC. Exception: special cases go directly to DONE with the result computed in the same cycle.
- Special cases (division only):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a==1<<(XLEN-1), b==all-ones): DIV gives a; REM gives 0.
- CALC:
  - Multiply: shift-add on a 2*XLEN accumulator, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle, with XLEN+1-bit remainder compare.
  - Counter runs 0..XLEN-1. At count XLEN-1, go to DONE and register the final result:
    - MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
    - Two's-complement negation is applied across the full 2*XLEN product (or to the quotient/remainder) when the negate flag is set.
- DONE:
  - res_valid_o=1; result_o and res_tag_o are held stable until res_ready_i.
  - On res_valid_o && res_ready_i: go to IDLE. op_ready_o rises the next cycle; there is no same-cycle accept.
- Latency, counting the accept edge as cycle 0:
  - Normal ops: res_valid_o is high in cycle XLEN+1 (33 for XLEN=32).
  - Special cases: res_valid_o is high in cycle 1.
- kill_i:
  - In any state, the next state is IDLE and res_valid_o=0 next cycle; no result is produced.
  - In IDLE, a request with kill_i high is not accepted.
  - kill_i in the same cycle as a DONE handshake: the result counts as consumed and the state goes to IDLE.
- result_o keeps its last value when not valid; consumers must qualify it with res_valid_o.
- Widths: internal accumulator is 2*XLEN bits; remainder register is XLEN+1 bits; counter is clog2(XLEN) bits.

Test Plan (XLEN=32):
- Signed multiply: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; res_valid_o rises exactly 33 cycles after accept; res_tag_o equals the request tag.
- High-word products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide and remainder:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with res_valid_o in cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold res_ready_i=0 for 10 cycles in DONE -> result_o and res_tag_o stable, op_ready_o=0; release -> one handshake, op_ready_o=1 the following cycle; back-to-back ops give correct independent results.
- Flush and reset:
  - kill_i at CALC step 10 -> no res_valid_o; IDLE and op_ready_o=1 next cycle; a following MUL 3*4 returns 12.
  - rst_i mid-CALC -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/milano_mdu.sv
// milano_mdu: iterative radix-2 multiply/divide unit for the RV32M/RV64M group.
// One shift-add or restoring-divide step per cycle, valid/ready on both sides.
module milano_mdu #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  logic [2:0]       op_i,
   input  logic [XLEN-1:0]  operand_a_i,
   input  logic [XLEN-1:0]  operand_b_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             kill_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] res_tag_o,
   output logic             busy_o
);

   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [TAG_W-1:0]  tag_q;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   mcand;
   logic [XLEN:0]     rem;
   logic [XLEN-1:0]   quo;

   logic              a_signed;
   logic              b_signed;
   logic              sign_a;
   logic              sign_b;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              neg_in;
   logic              div_zero;
   logic              div_ovf;
   logic              special;
   logic [XLEN-1:0]   special_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] acc_next;
   logic [2*XLEN-1:0] prod;
   logic [XLEN:0]     rem_sh;
   logic              rem_ge;
   logic [XLEN:0]     rem_next;
   logic [XLEN-1:0]   quo_next;
   logic [XLEN-1:0]   dres;
   logic [XLEN-1:0]   fin;

   assign op_ready_o  = (state == S_IDLE);
   assign busy_o      = (state != S_IDLE);
   assign res_valid_o = (state == S_DONE);

   // Request decode: operand magnitudes, sign fix-up and division corner cases.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op_i)
         OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      sign_a   = a_signed & operand_a_i[XLEN-1];
      sign_b   = b_signed & operand_b_i[XLEN-1];
      mag_a    = sign_a ? -operand_a_i : operand_a_i;
      mag_b    = sign_b ? -operand_b_i : operand_b_i;
      neg_in   = (op_i == OP_REM) ? sign_a : (sign_a ^ sign_b);
      div_zero = op_i[2] && (operand_b_i == '0);
      div_ovf  = op_i[2] && !op_i[0]
               && (operand_a_i == MIN_NEG)
               && (operand_b_i == ONES);
      special  = div_zero || div_ovf;
      special_res = '0;
      if (div_zero)
         special_res = op_i[1] ? operand_a_i : ONES;
      else if (div_ovf)
         special_res = op_i[1] ? '0 : operand_a_i;
   end

   // One iteration of both datapaths; the state machine keeps the relevant one.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
      acc_next = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                        : {1'b0, acc[2*XLEN-1:1]};
      prod     = neg_q ? -acc_next : acc_next;
      rem_sh   = {rem[XLEN-1:0], quo[XLEN-1]};
      rem_ge   = rem[XLEN] || (rem_sh >= {1'b0, mcand});
      rem_next = rem_ge ? (rem_sh - {1'b0, mcand}) : rem_sh;
      quo_next = {quo[XLEN-2:0], rem_ge};
      dres     = op_q[1] ? rem_next[XLEN-1:0] : quo_next;
      if (op_q[2])
         fin = neg_q ? -dres : dres;
      else if (op_q == OP_MUL)
         fin = prod[XLEN-1:0];
      else
         fin = prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         cnt       <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         tag_q     <= '0;
         acc       <= '0;
         mcand     <= '0;
         rem       <= '0;
         quo       <= '0;
         result_o  <= '0;
         res_tag_o <= '0;
      end else if (kill_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (op_valid_i) begin
                  op_q  <= op_i;
                  neg_q <= neg_in;
                  tag_q <= tag_i;
                  acc   <= {{XLEN{1'b0}}, mag_b};
                  mcand <= op_i[2] ? mag_b : mag_a;
                  rem   <= '0;
                  quo   <= mag_a;
                  cnt   <= '0;
                  if (special) begin
                     result_o  <= special_res;
                     res_tag_o <= tag_i;
                     state     <= S_DONE;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc <= acc_next;
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cnt       <= '0;
                  result_o  <= fin;
                  res_tag_o <= tag_q;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (res_ready_i)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
